// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI receive path.
package spi_pkg;
    typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_SHIFT} state_e;
    localparam int SPI_BITC_W = 5;
    localparam logic [SPI_BITC_W-1:0] SPI_LEN8 = 5'd8;
    localparam logic [SPI_BITC_W-1:0] SPI_LEN16 = 5'd16;
    localparam logic [SPI_BITC_W-1:0] SPI_BITC_MAX = 5'd17;
    localparam logic SCK_IDLE = 1'b0;
    localparam logic CEN_IDLE = 1'b1;
    localparam logic CDN_IDLE = 1'b1;
    localparam logic MOSI_IDLE = 1'b0;
endpackage

// File: rtl/spi_sync.sv
// spi_sync: N-flop pin synchroniser with a history flop for edge detection.
module spi_sync #(
    parameter int STAGES = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q;
    logic hist_q;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin};
            hist_q <= sync_q[STAGES-1];
        end
    end
    assign level = sync_q[STAGES-1];
    assign rise = level & ~hist_q;
    assign fall = ~level & hist_q;
endmodule

// File: rtl/spi_rx.sv
// spi_rx: SPI target receiver delivering 8/16-bit command/data words
// through a valid/ack holding register.
module spi_rx
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        spi_sck,
    input  logic        spi_cen,
    input  logic        spi_cdn,
    input  logic        spi_mosi,
    output logic [15:0] rx_data,
    output logic        rx_cmd,
    output logic        rx_is16,
    output logic        rx_valid,
    input  logic        rx_ack,
    output logic        frame_err,
    output logic        overrun
);
    localparam int FW = $clog2(SYNC_STAGES + 2);
    localparam logic [FW-1:0] FLUSH_N = FW'(SYNC_STAGES + 1);

    logic sck_lvl, sck_rise, sck_fall;
    logic cen_lvl, cen_rise, cen_fall;
    logic cdn_lvl, cdn_rise, cdn_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SCK_IDLE)) u_sck (
        .clk(clk), .rstn(rstn), .pin(spi_sck), .level(sck_lvl), .rise(sck_rise), .fall(sck_fall));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CEN_IDLE)) u_cen (
        .clk(clk), .rstn(rstn), .pin(spi_cen), .level(cen_lvl), .rise(cen_rise), .fall(cen_fall));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CDN_IDLE)) u_cdn (
        .clk(clk), .rstn(rstn), .pin(spi_cdn), .level(cdn_lvl), .rise(cdn_rise), .fall(cdn_fall));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(MOSI_IDLE)) u_mosi (
        .clk(clk), .rstn(rstn), .pin(spi_mosi), .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

    state_e state_q, state_d;
    logic [FW-1:0] flush_q;
    logic [15:0] shift_q, shift_d, word_d;
    logic [SPI_BITC_W-1:0] bitc_q, bitc_d;
    logic cmd_q, cmd_d, is16_d;
    logic sck_hit, start, done, good, err, flushed;
    logic [15:0] data_q;
    logic cmd_out_q, is16_q, valid_q, err_q, ovr_q;

    // Reset preloads idle pin levels, so stay in SYNC until the pipeline
    // holds real samples; a frame caught mid-flight is then discarded.
    assign flushed = flush_q == FLUSH_N;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_SYNC;
            flush_q <= '0;
            shift_q <= '0;
            bitc_q <= '0;
            cmd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flushed ? flush_q : flush_q + FW'(1);
            shift_q <= shift_d;
            bitc_q <= bitc_d;
            cmd_q <= cmd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC:  state_d = flushed && cen_lvl ? ST_IDLE : ST_SYNC;
            ST_IDLE:  state_d = cen_fall ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: state_d = cen_rise ? ST_IDLE : ST_SHIFT;
            default:  state_d = ST_SYNC;
        endcase
    end

    // Shift is applied before evaluation so a coincident last SCK rise counts.
    always_comb begin
        sck_hit = state_q == ST_SHIFT && sck_rise;
        start = state_q == ST_IDLE && cen_fall;
        shift_d = start ? '0 : sck_hit ? {shift_q[14:0], mosi_lvl} : shift_q;
        bitc_d = start ? '0 : (sck_hit && bitc_q != SPI_BITC_MAX) ? bitc_q + SPI_BITC_W'(1) : bitc_q;
        cmd_d = sck_hit && bitc_q == '0 ? ~cdn_lvl : cmd_q;
        done = state_q == ST_SHIFT && cen_rise;
        good = done && (bitc_d == SPI_LEN8 || bitc_d == SPI_LEN16);
        err = done && !good;
        is16_d = bitc_d == SPI_LEN16;
        word_d = is16_d ? shift_d : {8'h00, shift_d[7:0]};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            data_q <= '0;
            cmd_out_q <= 1'b0;
            is16_q <= 1'b0;
            valid_q <= 1'b0;
            err_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            if (good && (!valid_q || rx_ack)) begin
                data_q <= word_d;
                cmd_out_q <= cmd_d;
                is16_q <= is16_d;
            end
            valid_q <= good ? 1'b1 : rx_ack ? 1'b0 : valid_q;
            err_q <= err;
            ovr_q <= good && valid_q && !rx_ack;
        end
    end

    assign rx_data = data_q;
    assign rx_cmd = cmd_out_q;
    assign rx_is16 = is16_q;
    assign rx_valid = valid_q;
    assign frame_err = err_q;
    assign overrun = ovr_q;
endmodule

// File: tb/tb_spi_rx.sv
// tb_spi_rx: directed self-checking bench for spi_rx.
module tb_spi_rx;
    logic clk = 0, rstn = 0;
    logic spi_sck = 0, spi_cen = 1, spi_cdn = 1, spi_mosi = 0, rx_ack = 0;
    logic [15:0] rx_data;
    logic rx_cmd, rx_is16, rx_valid, frame_err, overrun;
    int checks = 0, failures = 0;
    int err_cnt = 0, ovr_cnt = 0, both_cnt = 0;

    spi_rx dut (
        .clk(clk), .rstn(rstn), .spi_sck(spi_sck), .spi_cen(spi_cen), .spi_cdn(spi_cdn),
        .spi_mosi(spi_mosi), .rx_data(rx_data), .rx_cmd(rx_cmd), .rx_is16(rx_is16),
        .rx_valid(rx_valid), .rx_ack(rx_ack), .frame_err(frame_err), .overrun(overrun));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (frame_err === 1'b1) err_cnt++;
        if (overrun === 1'b1) ovr_cnt++;
        if (frame_err === 1'b1 && overrun === 1'b1) both_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start(input logic cdn);
        spi_cen = 0;
        spi_cdn = cdn;
        tick(3);
    endtask

    task automatic bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = val[i];
            spi_sck = 0;
            tick(3);
            spi_sck = 1;
            tick(3);
        end
        spi_sck = 0;
        tick(3);
    endtask

    task automatic frame(input logic [31:0] val, input int n, input logic cdn);
        start(cdn);
        bits(val, n);
        spi_cen = 1;
    endtask

    task automatic ack;
        rx_ack = 1;
        tick(1);
        rx_ack = 0;
    endtask

    task automatic test_reset;
        rstn = 0;
        tick(3);
        checks++;
        if ({rx_data, rx_cmd, rx_is16, rx_valid, frame_err, overrun} !== 21'h0) begin
            failures++;
            $display("FAIL reset: got data=%h cmd=%b is16=%b valid=%b err=%b ovr=%b exp all zero",
                     rx_data, rx_cmd, rx_is16, rx_valid, frame_err, overrun);
        end
        rstn = 1;
        tick(6);
    endtask

    task automatic test_cmd8;
        frame(32'h2A, 8, 1'b0);
        tick(2);
        checks++;
        if (rx_valid !== 1'b0) begin failures++; $display("FAIL cmd8_early: got valid=%b exp 0", rx_valid); end
        tick(1);
        checks++;
        if ({rx_valid, rx_data, rx_cmd, rx_is16} !== {1'b1, 16'h002A, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL cmd8: got valid=%b data=%h cmd=%b is16=%b exp 1 002a 1 0", rx_valid, rx_data, rx_cmd, rx_is16);
        end
        ack();
        tick(3);
    endtask

    task automatic test_data16;
        frame(32'hF81F, 16, 1'b1);
        tick(3);
        checks++;
        if ({rx_valid, rx_data, rx_cmd, rx_is16} !== {1'b1, 16'hF81F, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL data16: got valid=%b data=%h cmd=%b is16=%b exp 1 f81f 0 1", rx_valid, rx_data, rx_cmd, rx_is16);
        end
        ack();
        checks++;
        if (rx_valid !== 1'b0) begin failures++; $display("FAIL data16_ack: got valid=%b exp 0", rx_valid); end
        tick(3);
    endtask

    task automatic test_frame_err;
        int e0 = err_cnt;
        frame(32'h15, 5, 1'b1);
        tick(4);
        frame(32'h1ABCD, 17, 1'b1);
        tick(4);
        checks++;
        if (err_cnt - e0 !== 2) begin failures++; $display("FAIL frame_err_count: got %0d exp 2", err_cnt - e0); end
        checks++;
        if (rx_valid !== 1'b0) begin failures++; $display("FAIL frame_err_valid: got valid=%b exp 0", rx_valid); end
    endtask

    task automatic test_back_to_back;
        int o0 = ovr_cnt;
        frame(32'h11, 8, 1'b1);
        tick(4);
        frame(32'h22, 8, 1'b1);
        tick(4);
        checks++;
        if ({rx_valid, rx_data} !== {1'b1, 16'h0011}) begin
            failures++;
            $display("FAIL overrun_keep: got valid=%b data=%h exp 1 0011", rx_valid, rx_data);
        end
        checks++;
        if (ovr_cnt - o0 !== 1) begin failures++; $display("FAIL overrun_count: got %0d exp 1", ovr_cnt - o0); end
        ack();
        tick(3);
        o0 = ovr_cnt;
        frame(32'h11, 8, 1'b1);
        tick(4);
        frame(32'h22, 8, 1'b1);
        tick(2);
        rx_ack = 1;
        tick(1);
        rx_ack = 0;
        tick(2);
        checks++;
        if ({rx_valid, rx_data} !== {1'b1, 16'h0022}) begin
            failures++;
            $display("FAIL ack_load: got valid=%b data=%h exp 1 0022", rx_valid, rx_data);
        end
        checks++;
        if (ovr_cnt - o0 !== 0) begin failures++; $display("FAIL ack_no_overrun: got %0d exp 0", ovr_cnt - o0); end
        ack();
        tick(3);
    endtask

    task automatic test_reset_mid;
        int e0 = err_cnt;
        start(1'b0);
        bits(32'hA, 4);
        rstn = 0;
        tick(2);
        rstn = 1;
        tick(10);
        spi_cen = 1;
        tick(8);
        checks++;
        if (rx_valid !== 1'b0 || err_cnt !== e0) begin
            failures++;
            $display("FAIL reset_mid: got valid=%b errs=%0d exp 0 0", rx_valid, err_cnt - e0);
        end
        frame(32'h55, 8, 1'b1);
        tick(4);
        checks++;
        if ({rx_valid, rx_data, rx_cmd} !== {1'b1, 16'h0055, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_55: got valid=%b data=%h cmd=%b exp 1 0055 0", rx_valid, rx_data, rx_cmd);
        end
        ack();
        tick(3);
    endtask

    task automatic test_cen_high_cdn;
        int e0 = err_cnt;
        for (int i = 0; i < 8; i++) begin
            spi_sck = 1;
            tick(3);
            spi_sck = 0;
            tick(3);
        end
        tick(4);
        checks++;
        if (rx_valid !== 1'b0 || err_cnt !== e0) begin
            failures++;
            $display("FAIL sck_cen_high: got valid=%b errs=%0d exp 0 0", rx_valid, err_cnt - e0);
        end
        start(1'b0);
        bits(32'h1, 1);
        spi_cdn = 1;
        bits(32'h25, 7);
        spi_cen = 1;
        tick(4);
        checks++;
        if ({rx_valid, rx_data, rx_cmd} !== {1'b1, 16'h00A5, 1'b1}) begin
            failures++;
            $display("FAIL cdn_late: got valid=%b data=%h cmd=%b exp 1 00a5 1", rx_valid, rx_data, rx_cmd);
        end
        ack();
        tick(3);
    endtask

    initial begin
        test_reset();
        test_cmd8();
        test_data16();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_cen_high_cdn();
        checks++;
        if (both_cnt !== 0) begin failures++; $display("FAIL err_ovr_overlap: got %0d exp 0", both_cnt); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_rx.md
# spi_rx

Receive-side SPI block for the Hack screen path: the target end of the 4-wire display link (SCK, CEN, CDN, MOSI) driven by the display SPI master. It synchronises the pins into `clk`, shifts MOSI MSB-first on SCK rising edges, and at frame end (CEN rising) delivers one 8-bit or 16-bit word, tagged command or data, through a valid/ack holding register. It serves as the display-side model in screen simulations and as the capture front end when an external host drives the screen port.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: metastability flops per pin, ≥ 2.

Ports:
- `clk` in 1: system clock.
- `rstn` in 1: reset, synchronous, active-low.
- `spi_sck` in 1: serial clock, idle low, asynchronous to `clk`.
- `spi_cen` in 1: chip enable, active-low; a frame is one low period.
- `spi_cdn` in 1: 0 = command, 1 = data; sampled at the first SCK rise of the frame.
- `spi_mosi` in 1: serial data, MSB first.
- `rx_data` out 16: received word; 8-bit frames are zero-extended into `[7:0]`.
- `rx_cmd` out 1: word was a command (CDN low).
- `rx_is16` out 1: word came from a 16-bit frame.
- `rx_valid` out 1: holding register full.
- `rx_ack` in 1: consumer takes the word; honoured only while `rx_valid` is high.
- `frame_err` out 1: one-cycle pulse on a frame whose bit count is neither 8 nor 16.
- `overrun` out 1: one-cycle pulse when a good frame completes while `rx_valid` is high and no `rx_ack` arrives in that cycle.

## Operation

- Each pin passes through `SYNC_STAGES` flops plus one history flop. Reset values: sck 0, cen 1, cdn 1, mosi 0. The edge detector flags rising or falling edges from the last two stages.
- Receiver FSM states:
  - SYNC (reset state): wait for synced cen = 1, then go to IDLE. This discards any frame already in progress at reset release.
  - IDLE: on a synced cen fall, clear `shift` and `bitc`, clear `first`, go to SHIFT.
  - SHIFT: on each synced sck rise:
    - `shift <= {shift[14:0], mosi}`.
    - `bitc` increments and saturates at 17.
    - On the first rise, latch cdn into `cmd_r`.
  - On a synced cen rise in SHIFT, evaluate the frame and return to IDLE:
    - `bitc` = 8: word = `{8'h00, shift[7:0]}`, is16 = 0.
    - `bitc` = 16: word = `shift`, is16 = 1.
    - Any other count, including 0 and 17: pulse `frame_err` and drop the frame.
- SCK edges while synced cen is high are ignored.
- Holding register:
  - On a good frame with `rx_valid` = 0, or with `rx_valid` = 1 and `rx_ack` = 1 in the same cycle: load `rx_data`, `rx_cmd`, `rx_is16` and set `rx_valid` = 1.
  - On a good frame with `rx_valid` = 1 and no `rx_ack`: keep the old word and pulse `overrun`.
  - `rx_ack` with no new word: clear `rx_valid`.
  - `rx_ack` while `rx_valid` = 0: no effect.
- CDN is sampled only at the first SCK rise. Changes to CDN later in the frame are ignored.

## Timing

- Output reset values:
  - `rx_data` = 16'h0000.
  - `rx_cmd`, `rx_is16`, `rx_valid`, `frame_err`, `overrun` = 0.
  - FSM state = SYNC.
- Latency: a pin edge is acted on `SYNC_STAGES` + 1 `clk` edges after the first edge that samples the new level. With the default, `rx_valid` rises 3 cycles after CEN goes high at the pin.
- Input requirements:
  - SCK high and low phases each ≥ `SYNC_STAGES` + 1 `clk` periods.
  - MOSI stable from at least one such window before the SCK rise.
  - CEN high ≥ `SYNC_STAGES` + 1 periods between frames.
  - A same-clock master with divider ≥ 3 meets these requirements.
- An SCK rise and a CEN rise detected in the same cycle: the shift is applied first, and the frame is then evaluated on the updated count.
- Reset mid-frame: all state clears and the FSM enters SYNC. No partial word or error pulse is emitted for the interrupted frame.
- `frame_err` and `overrun` are exactly one cycle wide and are never both high in the same cycle.

## Structure

- Package `spi_pkg`:
  - FSM state encodings SYNC, IDLE, SHIFT.
  - Frame-length constants `SPI_LEN8` = 8 and `SPI_LEN16` = 16.
  - Bit-counter width (5).
  - Pin idle levels.
- Sub-module `spi_sync`: a parameterised N-flop synchroniser with history flop. It has a reset value parameter and outputs `level`, `rise` and `fall`. It is instantiated once per pin.
- The top level holds the FSM, shift register, bit counter and holding register.

## Test plan

- Command byte 8'h2A, CDN = 0 → `rx_valid` = 1, `rx_data` = 16'h002A, `rx_cmd` = 1, `rx_is16` = 0, 3 cycles after CEN rises.
- 16-bit data 16'hF81F, CDN = 1 → `rx_data` = 16'hF81F, `rx_cmd` = 0, `rx_is16` = 1. Ack → `rx_valid` = 0 on the next cycle.
- Frame of 5 bits, then a frame of 17 bits → two `frame_err` pulses, `rx_valid` stays 0.
- Two back-to-back bytes 8'h11 and 8'h22, no ack → `rx_data` = 16'h0011 retained, one `overrun` pulse. Repeat with the ack in the completion cycle → `rx_data` = 16'h0022, no `overrun`.
- Reset asserted after 4 bits of a frame, CEN held low afterwards → no output; then a full 8'h55 frame → `rx_data` = 16'h0055.
- SCK toggled 8 times with CEN high, then a CDN change after the first SCK rise of a command frame → no word from the first; `rx_cmd` = 1 for the second.
